// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: request codes, status codes and FSM states shared by the memory arbiter files.
//   MEM_NOP/READ/WRITE   : requester command encodings
//   MEM_RESTING..FINISHED: per-requester status encodings
//   arb_state_e          : arbiter FSM states
package mem_arbiter_pkg;
  localparam logic [1:0] MEM_NOP   = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;
  localparam logic [1:0] MEM_RESTING       = 2'd0;
  localparam logic [1:0] MEM_WORKING       = 2'd1;
  localparam logic [1:0] MEM_INST_FINISHED = 2'd2;
  localparam logic [1:0] MEM_DATA_FINISHED = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} arb_state_e;
endpackage

// File: rtl/mem_arbiter_pick.sv
// mem_arb_pick: combinational grant selector for the memory arbiter.
//   pending_i, pending_d : requester wants the memory port
//   last_owner           : owner of the previous grant (0=I, 1=D)
//   grant                : some requester is pending
//   owner                : chosen requester (0=I, 1=D)
// A tie goes to the requester that is not last_owner; holding last_owner at 0
// therefore gives plain fixed D priority.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic pending_i,
  input  logic pending_d,
  input  logic last_owner,
  output logic grant,
  output logic owner
);
  always_comb begin
    grant = pending_i | pending_d;
    owner = pending_d & ~(pending_i & last_owner);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the I-side and D-side requesters.
//   clk, rst_n                         : clock, asynchronous active-low reset
//   i_vis_signal/i_vis_addr, i_status  : I-side request (NOP/READ) and status
//   d_vis_signal/d_vis_addr/d_wdata,
//   d_status                           : D-side request (NOP/READ/WRITE) and status
//   rdata                              : returned word, valid in the FINISHED cycle
//   mem_req/mem_we/mem_addr/mem_wdata  : memory request, held until mem_done
//   mem_rdata, mem_done                : memory response
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise D wins ties.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            i_vis_signal,
  input  logic [ADDR_WIDTH-1:0] i_vis_addr,
  output logic [1:0]            i_status,
  input  logic [1:0]            d_vis_signal,
  input  logic [ADDR_WIDTH-1:0] d_vis_addr,
  input  logic [LEN-1:0]        d_wdata,
  output logic [1:0]            d_status,
  output logic [LEN-1:0]        rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LEN-1:0]        mem_wdata,
  input  logic [LEN-1:0]        mem_rdata,
  input  logic                  mem_done
);
  arb_state_e            state, state_nx;
  logic                  owner, owner_nx;
  logic                  last_owner;
  logic                  grant, pick_owner;
  logic                  req_nx, we_nx;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic [LEN-1:0]        wdata_nx, rdata_nx;
  logic [1:0]            i_st_nx, d_st_nx;

  mem_arb_pick u_pick (
    .pending_i  (i_vis_signal == MEM_READ),
    .pending_d  (d_vis_signal != MEM_NOP),
    .last_owner (last_owner),
    .grant      (grant),
    .owner      (pick_owner)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_owner <= 1'b0;
    else if (state == ST_IDLE && grant) last_owner <= pick_owner;
`else
  assign last_owner = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= ST_IDLE;
      owner     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      i_status  <= MEM_RESTING;
      d_status  <= MEM_RESTING;
    end else begin
      state     <= state_nx;
      owner     <= owner_nx;
      mem_req   <= req_nx;
      mem_we    <= we_nx;
      mem_addr  <= addr_nx;
      mem_wdata <= wdata_nx;
      rdata     <= rdata_nx;
      i_status  <= i_st_nx;
      d_status  <= d_st_nx;
    end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    req_nx   = mem_req;
    we_nx    = mem_we;
    addr_nx  = mem_addr;
    wdata_nx = mem_wdata;
    rdata_nx = rdata;
    i_st_nx  = i_status;
    d_st_nx  = d_status;
    case (state)
      ST_IDLE:
        if (grant) begin
          state_nx = ST_BUSY;
          owner_nx = pick_owner;
          req_nx   = 1'b1;
          we_nx    = pick_owner & (d_vis_signal == MEM_WRITE);
          addr_nx  = pick_owner ? d_vis_addr : i_vis_addr;
          wdata_nx = d_wdata;
          i_st_nx  = pick_owner ? MEM_RESTING : MEM_WORKING;
          d_st_nx  = pick_owner ? MEM_WORKING : MEM_RESTING;
        end
      ST_BUSY:
        if (mem_done) begin
          state_nx = ST_DONE;
          req_nx   = 1'b0;
          rdata_nx = mem_rdata;
          i_st_nx  = owner ? MEM_RESTING : MEM_INST_FINISHED;
          d_st_nx  = owner ? MEM_DATA_FINISHED : MEM_RESTING;
        end
      default: begin
        state_nx = ST_IDLE;
        i_st_nx  = MEM_RESTING;
        d_st_nx  = MEM_RESTING;
      end
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter (directed table, hand sequences, random vs. model).
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  i_sig = 2'd0, d_sig = 2'd0;
  logic [16:0] i_addr = '0, d_addr = '0;
  logic [31:0] d_wdata = '0, mem_rdata = '0;
  logic        mem_done = 1'b0;
  logic [1:0]  i_status, d_status;
  logic [31:0] rdata, mem_wdata;
  logic        mem_req, mem_we;
  logic [16:0] mem_addr;
  int checks = 0, failures = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_vis_signal(i_sig), .i_vis_addr(i_addr), .i_status(i_status),
    .d_vis_signal(d_sig), .d_vis_addr(d_addr), .d_wdata(d_wdata), .d_status(d_status),
    .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", n, a, e, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Transaction-level reference: timestamps of grant and finish, next legal grant edge.
  int t = 0, fin_t = -10, next_ok = 0;
  bit act = 0, m_own = 0, m_we = 0, fin_own = 0, m_last = 0;
  logic [16:0] m_addr = '0;
  logic [31:0] m_wdata = '0, fin_dat = '0;

  always @(posedge clk or negedge rst_n) begin
    bit pi, pd, own;
    if (!rst_n) begin
      t = 0; act = 0; fin_t = -10; next_ok = 0; m_last = 0;
    end else begin
      t++;
      if (act) begin
        if (mem_done) begin
          act = 0; fin_t = t; fin_own = m_own; fin_dat = mem_rdata; next_ok = t + 2;
        end
      end else if (t >= next_ok) begin
        pi = (i_sig == 2'd1);
        pd = (d_sig != 2'd0);
        if (pi || pd) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          if (pi && pd) own = !m_last; else own = pd;
`else
          own = pd;
`endif
          act = 1; m_own = own; m_last = own;
          m_addr = own ? d_addr : i_addr;
          m_we = own && (d_sig == 2'd2);
          m_wdata = d_wdata;
        end
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("model_req", 32'(mem_req), 32'(act));
    chk("model_ist", 32'(i_status), (act && !m_own) ? 1 : ((fin_t == t && !fin_own) ? 2 : 0));
    chk("model_dst", 32'(d_status), (act && m_own) ? 1 : ((fin_t == t && fin_own) ? 3 : 0));
    if (act) begin
      chk("model_addr", 32'(mem_addr), 32'(m_addr));
      chk("model_we", 32'(mem_we), 32'(m_we));
      if (m_we) chk("model_wdata", mem_wdata, m_wdata);
    end
    if (fin_t == t) chk("model_rdata", rdata, fin_dat);
  end

  typedef struct {
    logic [1:0] is, ds;
    logic [16:0] ia, da;
    logic [31:0] wd, rd;
    int lat;
    bit grant, own, we;
    logic [16:0] addr;
  } vec_t;

  vec_t vt [8];

  initial begin
    logic [16:0] a;
    bit exp_own;
    vt[0] = '{2'd1, 2'd0, 17'h00abc, 17'h0, 32'h0, 32'h11111111, 1, 1, 0, 0, 17'h00abc};
    vt[1] = '{2'd0, 2'd1, 17'h0, 17'h1fffc, 32'h0, 32'h22222222, 2, 1, 1, 0, 17'h1fffc};
    vt[2] = '{2'd0, 2'd2, 17'h0, 17'h00004, 32'ha5a5a5a5, 32'h33333333, 1, 1, 1, 1, 17'h00004};
    vt[3] = '{2'd2, 2'd0, 17'h00111, 17'h0, 32'h0, 32'h0, 1, 0, 0, 0, 17'h0};
    vt[4] = '{2'd2, 2'd1, 17'h00333, 17'h00020, 32'h0, 32'h44444444, 1, 1, 1, 0, 17'h00020};
    vt[5] = '{2'd1, 2'd0, 17'h1ffff, 17'h0, 32'h0, 32'hffffffff, 5, 1, 0, 0, 17'h1ffff};
    vt[6] = '{2'd0, 2'd0, 17'h0, 17'h0, 32'h0, 32'h0, 1, 0, 0, 0, 17'h0};
    vt[7] = '{2'd0, 2'd2, 17'h0, 17'h00000, 32'h0, 32'hcafef00d, 3, 1, 1, 1, 17'h00000};

    repeat (2) tick();
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_ist", 32'(i_status), 0);
    chk("rst_dst", 32'(d_status), 0);
    chk("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    chk_en = 1;

    // I-only read, 4 WORKING cycles then INST_FINISHED
    i_sig = 2'd1; i_addr = 17'h00010;
    tick();
    i_sig = 2'd0;
    for (int k = 0; k < 4; k++) begin
      chk("ird_working", 32'(i_status), 1);
      chk("ird_addr", 32'(mem_addr), 32'h10);
      if (k == 3) begin mem_done = 1'b1; mem_rdata = 32'hdeadbeef; end
      tick();
    end
    mem_done = 1'b0;
    chk("ird_finished", 32'(i_status), 2);
    chk("ird_rdata", rdata, 32'hdeadbeef);
    tick();
    chk("ird_resting", 32'(i_status), 0);

    // D write with fields changing after grant
    d_sig = 2'd2; d_addr = 17'h00100; d_wdata = 32'h12345678;
    tick();
    d_sig = 2'd0; d_addr = 17'h1aaaa; d_wdata = 32'h0badf00d;
    for (int k = 0; k < 3; k++) begin
      chk("dwr_we", 32'(mem_we), 1);
      chk("dwr_addr", 32'(mem_addr), 32'h100);
      chk("dwr_wdata", mem_wdata, 32'h12345678);
      chk("dwr_dst", 32'(d_status), 1);
      if (k == 2) begin mem_done = 1'b1; mem_rdata = 32'h00000077; end
      tick();
    end
    mem_done = 1'b0;
    chk("dwr_finished", 32'(d_status), 3);
    tick();
    chk("dwr_resting", 32'(d_status), 0);

    // Reset in the middle of a D write; late mem_done ignored
    d_sig = 2'd2; d_addr = 17'h00044; d_wdata = 32'h55aa55aa;
    tick();
    d_sig = 2'd0;
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_req", 32'(mem_req), 0);
    chk("mrst_we", 32'(mem_we), 0);
    chk("mrst_addr", 32'(mem_addr), 0);
    chk("mrst_wdata", mem_wdata, 0);
    chk("mrst_rdata", rdata, 0);
    chk("mrst_dst", 32'(d_status), 0);
    tick();
    rst_n = 1'b1;
    tick();
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("late_done_dst", 32'(d_status), 0);
    chk("late_done_ist", 32'(i_status), 0);
    chk("late_done_req", 32'(mem_req), 0);

    // Table of single transactions
    for (int k = 0; k < 8; k++) begin
      i_sig = vt[k].is; d_sig = vt[k].ds; i_addr = vt[k].ia; d_addr = vt[k].da; d_wdata = vt[k].wd;
      tick();
      i_sig = 2'd0; d_sig = 2'd0;
      if (!vt[k].grant) begin
        chk("vec_nogrant_req", 32'(mem_req), 0);
        chk("vec_nogrant_ist", 32'(i_status), 0);
        chk("vec_nogrant_dst", 32'(d_status), 0);
        continue;
      end
      chk("vec_req", 32'(mem_req), 1);
      chk("vec_we", 32'(mem_we), 32'(vt[k].we));
      chk("vec_addr", 32'(mem_addr), 32'(vt[k].addr));
      chk("vec_ist", 32'(i_status), vt[k].own ? 0 : 1);
      chk("vec_dst", 32'(d_status), vt[k].own ? 1 : 0);
      repeat (vt[k].lat - 1) tick();
      mem_done = 1'b1; mem_rdata = vt[k].rd;
      tick();
      mem_done = 1'b0;
      chk("vec_ist_fin", 32'(i_status), vt[k].own ? 0 : 2);
      chk("vec_dst_fin", 32'(d_status), vt[k].own ? 3 : 0);
      chk("vec_rdata", rdata, vt[k].rd);
      tick();
    end

    // Tie right after reset: D first, I waits RESTING, I granted 2 cycles after FINISHED
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    i_sig = 2'd1; i_addr = 17'h00200; d_sig = 2'd1; d_addr = 17'h00300;
    tick();
    d_sig = 2'd0;
    chk("tie_d_working", 32'(d_status), 1);
    chk("tie_i_wait", 32'(i_status), 0);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("tie_d_fin", 32'(d_status), 3);
    chk("tie_i_wait2", 32'(i_status), 0);
    tick();
    chk("tie_gap_req", 32'(mem_req), 0);
    chk("tie_i_wait3", 32'(i_status), 0);
    tick();
    i_sig = 2'd0;
    chk("tie_i_working", 32'(i_status), 1);
    chk("tie_i_addr", 32'(mem_addr), 32'h200);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("tie_i_fin", 32'(i_status), 2);
    tick();

    // Repeated fresh ties: alternate under round robin, always D otherwise
    for (int k = 0; k < 4; k++) begin
      i_sig = 2'd1; d_sig = 2'd1; i_addr = 17'h00400 + 17'(k); d_addr = 17'h00500 + 17'(k);
      tick();
      i_sig = 2'd0; d_sig = 2'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_own = (k % 2 == 0);
`else
      exp_own = 1;
`endif
      chk("rr_dst", 32'(d_status), exp_own ? 1 : 0);
      chk("rr_ist", 32'(i_status), exp_own ? 0 : 1);
      chk("rr_addr", 32'(mem_addr), exp_own ? 32'(d_addr) : 32'(i_addr));
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      tick();
    end

    // I held at READ with 1-cycle memory: back-to-back every 3 cycles
    a = 17'h01000;
    i_sig = 2'd1; i_addr = a;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("b2b_req", 32'(mem_req), 1);
      chk("b2b_addr", 32'(mem_addr), 32'(a));
      chk("b2b_working", 32'(i_status), 1);
      mem_done = 1'b1; mem_rdata = 32'(k) + 32'h100;
      tick();
      mem_done = 1'b0;
      chk("b2b_fin", 32'(i_status), 2);
      a = a + 17'd4; i_addr = a;
      tick();
      chk("b2b_gap", 32'(mem_req), 0);
      tick();
    end
    i_sig = 2'd0;
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    tick();

    // Random traffic checked by the reference model
    for (int k = 0; k < 400; k++) begin
      i_sig = 2'($urandom_range(0, 2));
      d_sig = 2'($urandom_range(0, 2));
      i_addr = 17'($urandom);
      d_addr = 17'($urandom);
      d_wdata = $urandom;
      mem_rdata = $urandom;
      mem_done = ($urandom_range(0, 2) == 0);
      tick();
    end
    i_sig = 2'd0; d_sig = 2'd0; mem_done = 1'b1;
    repeat (3) tick();
    mem_done = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
